// File: rtl/stc_dbuffer_drain_if.sv
// stc_dbuffer_drain_if: D-buffer read port and memory write channel of the drain engine
//   rd_col    : column index to the buffer (master -> slave)
//   d_row     : buffer D_row_out, combinational in rd_col (slave -> master)
//   mem_valid : write beat valid (master -> slave)
//   mem_ready : memory accepts beat on valid && ready (slave -> master)
//   mem_addr  : byte address of the beat (master -> slave)
//   mem_data  : row data beat (master -> slave)
interface stc_dbuffer_drain_if #(
  parameter int N       = 16,
  parameter int DW_DATA = 16,
  parameter int DW_MEM  = 256,
  parameter int DW_COL  = 4,
  parameter int DW_ADDR = 32
);
  logic [DW_COL-1:0]    rd_col;
  logic [N*DW_DATA-1:0] d_row;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [DW_ADDR-1:0]   mem_addr;
  logic [DW_MEM-1:0]    mem_data;
  modport master (output rd_col, mem_valid, mem_addr, mem_data, input d_row, mem_ready);
  modport slave (input rd_col, mem_valid, mem_addr, mem_data, output d_row, mem_ready);
endinterface

// File: rtl/stc_dbuffer_drain.sv
// stc_dbuffer_drain: streams the M rows of the D accumulator buffer to memory, one row per beat
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   start_i     : one-cycle drain request, honoured only when idle
//   base_addr_i : byte address of row 0, sampled on accepted start
//   busy_o      : drain in progress (cycle after start through done cycle)
//   done_o      : one-cycle pulse after the final beat is accepted
//   bus         : buffer column read port and valid/ready memory write channel
module stc_dbuffer_drain #(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int DW_DATA = 16,
  parameter int DW_MEM  = 256,
  parameter int DW_COL  = 4,
  parameter int DW_ADDR = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [DW_ADDR-1:0]  base_addr_i,
  output logic                busy_o,
  output logic                done_o,
  stc_dbuffer_drain_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  localparam logic [DW_ADDR-1:0] STRIDE = DW_ADDR'(DW_MEM / 8);
  localparam logic [DW_COL-1:0]  LAST   = DW_COL'(M - 1);
  if (DW_MEM != N * DW_DATA) begin : g_bad_width
    $fatal(1, "stc_dbuffer_drain: DW_MEM must equal N*DW_DATA");
  end
  if ((1 << DW_COL) < M) begin : g_bad_col
    $fatal(1, "stc_dbuffer_drain: DW_COL too narrow for M");
  end
  state_t              state_q, state_d;
  logic [DW_COL-1:0]   rd_row_q, rd_row_d;
  logic [DW_ADDR-1:0]  base_q, base_d;
  logic [DW_MEM-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [DW_ADDR-1:0]  head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
  logic                head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic                pop, push, head_load, from_tail, from_new, tail_load;
  logic [DW_ADDR-1:0]  new_addr;
  // Two-register FIFO: head feeds the memory channel directly, tail is the overflow slot.
  // A push is allowed when full only if the head is popped the same cycle.
  assign pop       = head_v_q && bus.mem_ready;
  assign push      = (state_q == READ) && (!(head_v_q && tail_v_q) || pop);
  assign new_addr  = base_q + DW_ADDR'(rd_row_q) * STRIDE;
  assign head_load = !head_v_q || pop;
  assign from_tail = head_load && tail_v_q;
  assign from_new  = head_load && !tail_v_q && push;
  assign tail_load = push && !from_new;
  // Head data/address hold their last values when the FIFO drains empty.
  assign head_data_d = from_tail ? tail_data_q : (from_new ? bus.d_row : head_data_q);
  assign head_addr_d = from_tail ? tail_addr_q : (from_new ? new_addr : head_addr_q);
  assign head_v_d    = head_load ? (tail_v_q || push) : 1'b1;
  assign tail_data_d = tail_load ? bus.d_row : tail_data_q;
  assign tail_addr_d = tail_load ? new_addr : tail_addr_q;
  assign tail_v_d    = tail_load ? 1'b1 : (from_tail ? 1'b0 : tail_v_q);
  always_comb begin
    state_d  = state_q;
    rd_row_d = rd_row_q;
    base_d   = base_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d  = READ;
        base_d   = base_addr_i;
        rd_row_d = '0;
      end
      READ: if (push) begin
        if (rd_row_q == LAST) state_d = FLUSH;
        else rd_row_d = rd_row_q + DW_COL'(1);
      end
      FLUSH: if (!tail_v_q && head_load) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_row_q    <= '0;
      base_q      <= '0;
      head_data_q <= '0;
      head_addr_q <= '0;
      head_v_q    <= 1'b0;
      tail_data_q <= '0;
      tail_addr_q <= '0;
      tail_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      base_q      <= base_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      head_v_q    <= head_v_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
      tail_v_q    <= tail_v_d;
    end
  end
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DONE;
  assign bus.rd_col    = rd_row_q;
  assign bus.mem_valid = head_v_q;
  assign bus.mem_addr  = head_addr_q;
  assign bus.mem_data  = head_data_q;
endmodule

// File: tb/tb_stc_dbuffer_drain.sv
// tb_stc_dbuffer_drain: directed self-checking bench for the D-buffer drain engine
module tb_stc_dbuffer_drain;
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [31:0] base = '0;
  logic        busy, done;
  int          pass_cnt = 0;
  int          total = 0;
  stc_dbuffer_drain_if #(.N(16), .DW_DATA(16), .DW_MEM(256), .DW_COL(4), .DW_ADDR(32)) bus ();
  stc_dbuffer_drain #(.N(16), .M(16), .DW_DATA(16), .DW_MEM(256), .DW_COL(4), .DW_ADDR(32)) dut (
    .clk(clk), .reset(reset), .start_i(start), .base_addr_i(base),
    .busy_o(busy), .done_o(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always_comb begin
    bus.d_row = '0;
    for (int j = 0; j < 16; j++) bus.d_row[j*16 +: 16] = 16'(int'(bus.rd_col) * 16 + j);
  end
  function automatic logic [255:0] row(input int i);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = 16'(i * 16 + j);
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [31:0] a);
    base = a;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic test_reset;
    reset = 0;
    bus.mem_ready = 0;
    repeat (2) tick;
    total++;
    if ({busy, done, bus.mem_valid} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, bus.mem_valid});
    else pass_cnt++;
    total++;
    if (bus.rd_col !== 4'd0) $display("FAIL reset_rd_col got %0d exp 0", bus.rd_col);
    else pass_cnt++;
    total++;
    if (bus.mem_addr !== 32'd0) $display("FAIL reset_addr got %h exp 0", bus.mem_addr);
    else pass_cnt++;
    total++;
    if (bus.mem_data !== 256'd0) $display("FAIL reset_data got %h exp 0", bus.mem_data);
    else pass_cnt++;
    reset = 1;
    tick;
  endtask
  task automatic test_full_rate;
    bus.mem_ready = 1;
    pulse_start(32'h1000);
    total++;
    if ({bus.mem_valid, bus.rd_col, busy} !== 6'b0_0000_1) $display("FAIL fr_cycle1 got %b exp 000001", {bus.mem_valid, bus.rd_col, busy});
    else pass_cnt++;
    for (int c = 2; c <= 17; c++) begin
      tick;
      total++;
      if ({bus.mem_valid, done, bus.mem_addr, bus.mem_data} !== {2'b10, 32'h1000 + 32'((c - 2) * 32), row(c - 2)})
        $display("FAIL fr_beat%0d got v=%b d=%b a=%h data=%h exp a=%h", c - 2, bus.mem_valid, done, bus.mem_addr, bus.mem_data, 32'h1000 + 32'((c - 2) * 32));
      else pass_cnt++;
    end
    tick;
    total++;
    if ({done, busy, bus.mem_valid} !== 3'b110) $display("FAIL fr_done18 got %b exp 110", {done, busy, bus.mem_valid});
    else pass_cnt++;
    start = 1;
    base = 32'h5000;
    tick;
    start = 0;
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL fr_idle19 got %b exp 00", {busy, done});
    else pass_cnt++;
    tick;
    total++;
    if ({busy, bus.mem_valid} !== 2'b00) $display("FAIL fr_done_start_ignored got %b exp 00", {busy, bus.mem_valid});
    else pass_cnt++;
  endtask
  task automatic test_stall_toggle;
    int k = 0;
    int dn = 0;
    logic stall = 0;
    logic [31:0] ha = '0;
    logic [255:0] hd = '0;
    bus.mem_ready = 0;
    pulse_start(32'h1000);
    for (int c = 1; c < 100 && dn == 0; c++) begin
      bus.mem_ready = (c % 2 == 1);
      if (stall) begin
        total++;
        if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, ha, hd}) $display("FAIL tg_stable c%0d got v=%b a=%h exp a=%h", c, bus.mem_valid, bus.mem_addr, ha);
        else pass_cnt++;
      end
      total++;
      if (int'(bus.rd_col) > k + 2) $display("FAIL tg_rd_col c%0d got %0d exp <=%0d", c, bus.rd_col, k + 2);
      else pass_cnt++;
      if (bus.mem_valid && bus.mem_ready) begin
        total++;
        if ({bus.mem_addr, bus.mem_data} !== {32'h1000 + 32'(k * 32), row(k)}) $display("FAIL tg_beat%0d got a=%h data=%h exp a=%h", k, bus.mem_addr, bus.mem_data, 32'h1000 + 32'(k * 32));
        else pass_cnt++;
        k++;
      end
      stall = bus.mem_valid && !bus.mem_ready;
      ha = bus.mem_addr;
      hd = bus.mem_data;
      if (done) dn++;
      tick;
    end
    total++;
    if (k !== 16) $display("FAIL tg_beat_count got %0d exp 16", k);
    else pass_cnt++;
    total++;
    if (dn !== 1) $display("FAIL tg_done_count got %0d exp 1", dn);
    else pass_cnt++;
  endtask
  task automatic test_stall_10;
    int k = 0;
    int dn = 0;
    bus.mem_ready = 0;
    pulse_start(32'h1000);
    repeat (9) tick;
    total++;
    if (bus.rd_col !== 4'd2) $display("FAIL st_rd_col got %0d exp 2", bus.rd_col);
    else pass_cnt++;
    total++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 32'h1000, row(0)}) $display("FAIL st_head got v=%b a=%h exp v=1 a=00001000", bus.mem_valid, bus.mem_addr);
    else pass_cnt++;
    bus.mem_ready = 1;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      if (bus.mem_valid) begin
        total++;
        if ({bus.mem_addr, bus.mem_data} !== {32'h1000 + 32'(k * 32), row(k)}) $display("FAIL st_beat%0d got a=%h data=%h exp a=%h", k, bus.mem_addr, bus.mem_data, 32'h1000 + 32'(k * 32));
        else pass_cnt++;
        k++;
      end
      if (done) dn++;
      tick;
    end
    total++;
    if ({k, dn} !== {32'd16, 32'd1}) $display("FAIL st_counts got beats=%0d done=%0d exp 16/1", k, dn);
    else pass_cnt++;
  endtask
  task automatic test_back_to_back_start;
    int k = 0;
    int dn = 0;
    bus.mem_ready = 1;
    pulse_start(32'h1000);
    for (int c = 1; c < 40 && dn == 0; c++) begin
      start = (c == 5);
      base = (c == 5) ? 32'h9000 : 32'h1000;
      if (bus.mem_valid) begin
        total++;
        if ({bus.mem_addr, bus.mem_data} !== {32'h1000 + 32'(k * 32), row(k)}) $display("FAIL bb_beat%0d got a=%h data=%h exp a=%h", k, bus.mem_addr, bus.mem_data, 32'h1000 + 32'(k * 32));
        else pass_cnt++;
        k++;
      end
      if (done) dn++;
      tick;
    end
    start = 0;
    total++;
    if ({k, dn} !== {32'd16, 32'd1}) $display("FAIL bb_counts got beats=%0d done=%0d exp 16/1", k, dn);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL bb_idle got busy=%b exp 0", busy);
    else pass_cnt++;
  endtask
  task automatic test_reset_abort;
    int k = 0;
    int dn = 0;
    bus.mem_ready = 1;
    pulse_start(32'h1000);
    repeat (7) tick;
    total++;
    if ({bus.mem_valid, busy} !== 2'b11) $display("FAIL ab_pre got %b exp 11", {bus.mem_valid, busy});
    else pass_cnt++;
    #2 reset = 0;
    #1;
    total++;
    if ({bus.mem_valid, busy, done, bus.rd_col} !== 7'd0) $display("FAIL ab_async got v=%b b=%b d=%b col=%0d exp all 0", bus.mem_valid, busy, done, bus.rd_col);
    else pass_cnt++;
    tick;
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL ab_held got %b exp 00", {busy, done});
    else pass_cnt++;
    reset = 1;
    tick;
    pulse_start(32'h2000);
    for (int c = 1; c < 40 && dn == 0; c++) begin
      if (bus.mem_valid) begin
        total++;
        if ({bus.mem_addr, bus.mem_data} !== {32'h2000 + 32'(k * 32), row(k)}) $display("FAIL ab_beat%0d got a=%h data=%h exp a=%h", k, bus.mem_addr, bus.mem_data, 32'h2000 + 32'(k * 32));
        else pass_cnt++;
        k++;
      end
      if (done) dn++;
      tick;
    end
    total++;
    if ({k, dn} !== {32'd16, 32'd1}) $display("FAIL ab_counts got beats=%0d done=%0d exp 16/1", k, dn);
    else pass_cnt++;
  endtask
  task automatic test_addr_wrap;
    bus.mem_ready = 1;
    pulse_start(32'hFFFF_FFE0);
    tick;
    total++;
    if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'hFFFF_FFE0}) $display("FAIL wr_beat0 got v=%b a=%h exp 1 ffffffe0", bus.mem_valid, bus.mem_addr);
    else pass_cnt++;
    tick;
    total++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 32'h0, row(1)}) $display("FAIL wr_beat1 got v=%b a=%h exp 1 00000000", bus.mem_valid, bus.mem_addr);
    else pass_cnt++;
    for (int c = 0; c < 40 && !done; c++) tick;
    total++;
    if (done !== 1'b1) $display("FAIL wr_done got %b exp 1", done);
    else pass_cnt++;
    tick;
  endtask
  initial begin
    bus.mem_ready = 0;
    test_reset;
    test_full_rate;
    test_stall_toggle;
    test_stall_10;
    test_back_to_back_start;
    test_reset_abort;
    test_addr_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/stc_dbuffer_drain.md
Name: stc_dbuffer_drain

Overview:
- Read-side drain engine for the D accumulator buffer (stc_Dbuffer).
- After the PEs finish writing D rows, it walks columns 0..M-1 over the buffer's col / D_row_out port and streams each row to memory as one DW_MEM-wide beat on a valid/ready write channel.
- A 2-entry output FIFO decouples buffer reads from memory back-pressure.

Parameters:
- N, 16, elements per D row
- M, 16, rows (columns of the buffer) to drain
- DW_DATA, 16, element width
- DW_MEM, 256, memory beat width; must equal N*DW_DATA (elaboration-time check; mismatch is a fatal error)
- DW_COL, 4, buffer column index width; 2^DW_COL >= M
- DW_ADDR, 32, byte address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to drain; ignored unless idle
- base_addr  in  DW_ADDR  byte address of row 0; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse after the final beat is accepted
- rd_col  out  DW_COL  column index driven to the buffer's col input
- D_row_in  in  N*DW_DATA  buffer D_row_out; combinational function of rd_col, valid in the same cycle
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts the beat when valid && ready
- mem_addr  out  DW_ADDR  byte address of the current beat
- mem_data  out  DW_MEM  row data; element j occupies bits [j*DW_DATA +: DW_DATA]

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; row counter, FIFO pointers and count cleared.
  - busy=0, done=0, mem_valid=0, rd_col=0, mem_addr=0, mem_data=0.
  - Asserting reset mid-drain aborts immediately. The in-flight beat is dropped and no done pulse is produced.
- States: IDLE, READ, FLUSH, DONE.
  - IDLE: start==1 latches base_addr, clears rd_row, goes to READ.
  - READ:
    - rd_col = rd_row.
    - If the FIFO is not full, or becomes not full this cycle because of a pop, push {D_row_in, base_addr + rd_row*(DW_MEM/8)} and increment rd_row.
    - After pushing row M-1, go to FLUSH.
    - If the FIFO is full with no pop, hold rd_row and rd_col.
  - FLUSH: no reads; rd_col holds M-1. Go to DONE in the cycle the FIFO empties, i.e. after the last handshake.
  - DONE: done=1 for exactly one cycle, busy still 1, then IDLE.
- FIFO and memory channel:
  - 2 entries; head drives mem_valid, mem_addr and mem_data directly from registers.
  - Pop on mem_valid && mem_ready. Push and pop in the same cycle are both allowed, including when the FIFO is full.
  - mem_valid, mem_addr and mem_data stay stable while mem_valid && !mem_ready. Once mem_valid rises it does not drop before the handshake.
  - When the FIFO is empty, mem_valid=0 and mem_data/mem_addr hold their last values.
- Latency with start in cycle 0 and mem_ready held at 1:
  - rd_col=0 in cycle 1; first beat (mem_valid=1) in cycle 2.
  - One beat per cycle; the last beat is in cycle M+1.
  - done=1 in cycle M+2; busy=0 in cycle M+3.
- Address arithmetic: addresses increment by DW_MEM/8 bytes (32 by default), modulo 2^DW_ADDR, with silent wrap.
- Boundary and illegal conditions:
  - start while busy: ignored, no effect on the drain.
  - start in the DONE cycle: ignored.
  - mem_ready asserted while mem_valid=0: no effect.
- Buffer interface: the block never drives the buffer's write enables. The system must not write the buffer while busy=1.

Test Plan:
- Preload the buffer so row i element j = i*16+j; set base_addr=0x1000, pulse start, hold mem_ready=1 -> 16 beats at mem_addr 0x1000, 0x1020, …, 0x11E0. Beat i element j equals i*16+j. done pulses in cycle 18 after start.
- Same data, mem_ready toggling 1,0,1,0… -> identical beat sequence with no loss or duplication. Beat contents are stable during each stall. rd_col never advances past FIFO capacity.
- mem_ready=0 for 10 cycles after start -> exactly 2 rows are read (rd_col stops at 2) and mem_valid holds row 0. Releasing mem_ready then completes all 16 beats in order.
- Second start pulsed in cycle 5 of a drain -> ignored; exactly 16 beats and one done pulse.
- Drop reset to 0 in cycle 8 of a drain -> mem_valid, busy and rd_col go to 0 asynchronously with no done pulse. A new start then drains all 16 rows from row 0.
- base_addr=0xFFFFFFE0 -> second beat address wraps to 0x00000000.
